// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU register bank: geometry and clear-sequencer state encoding.
package cpu8_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_COUNT  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile32_nbit_if.sv
// Register-bank port bundle: write port, two read ports and the clear handshake.
interface regfile32_nbit_if #(
  parameter int unsigned N = 8
);
  import cpu8_pkg::*;

  logic                  we;
  logic [REG_ADDR_W-1:0] waddr;
  logic [N-1:0]          wdata;
  logic [REG_ADDR_W-1:0] raddr_a;
  logic [REG_ADDR_W-1:0] raddr_b;
  logic [N-1:0]          rdata_a;
  logic [N-1:0]          rdata_b;
  logic                  clr_req;
  logic                  busy;
  logic                  clr_done;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, clr_req,
    input  rdata_a, rdata_b, busy, clr_done
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, clr_req,
    output rdata_a, rdata_b, busy, clr_done
  );

endinterface

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: walks every register address once, one per cycle, and flags busy/done.
module regfile_clr_seq
  import cpu8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  clr_active,
  output logic [REG_ADDR_W-1:0] clr_addr
);

  rf_state_e             state_q, state_d;
  logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  clr_done_q, clr_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      CLEAR: begin
        // Counter wraps to zero naturally after the last entry.
        cnt_d = cnt_q + REG_ADDR_W'(1);
        if (cnt_q == REG_ADDR_W'(REG_COUNT - 1)) begin
          state_d    = IDLE;
          busy_d     = 1'b0;
          clr_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = busy_q;
  assign clr_done   = clr_done_q;
  assign clr_active = (state_q == CLEAR);
  assign clr_addr   = cnt_q;

endmodule

// File: rtl/regfile32_nbit.sv
// 32-entry N-bit register bank with two registered read ports, write-through bypass and a clear sequencer.
// Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module regfile32_nbit
  import cpu8_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned ADDR_W = REG_ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile32_nbit_if.slave    bus
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic              clr_active;
  logic [ADDR_W-1:0] clr_addr;
  logic              busy;
  logic              clr_done;
  logic              wr_en;
  logic [N-1:0]      mem_q [REG_COUNT];
  logic [N-1:0]      mem_d [REG_COUNT];
  logic [N-1:0]      rdata_a_q, rdata_a_d;
  logic [N-1:0]      rdata_b_q, rdata_b_d;

  regfile_clr_seq u_clr_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (bus.clr_req),
    .busy       (busy),
    .clr_done   (clr_done),
    .clr_active (clr_active),
    .clr_addr   (clr_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) mem_q[i] <= '0;
      rdata_a_q <= '0;
      rdata_b_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rdata_a_q <= rdata_a_d;
      rdata_b_q <= rdata_b_d;
    end
  end

  // A clear in progress or starting this cycle swallows the write.
  always_comb begin
    wr_en = bus.we & ~clr_active & ~bus.clr_req;
    if (ZERO_REG && bus.waddr == ADDR_W'(0)) wr_en = 1'b0;

    mem_d = mem_q;
    if (wr_en)      mem_d[bus.waddr] = bus.wdata;
    if (clr_active) mem_d[clr_addr]  = '0;
  end

  // Read mux: stored value, overridden by same-cycle write, then by the entry being cleared.
  always_comb begin
    rdata_a_d = mem_q[bus.raddr_a];
    if (wr_en && bus.waddr == bus.raddr_a)       rdata_a_d = bus.wdata;
    if (clr_active && clr_addr == bus.raddr_a)   rdata_a_d = '0;
    if (ZERO_REG && bus.raddr_a == ADDR_W'(0))   rdata_a_d = '0;

    rdata_b_d = mem_q[bus.raddr_b];
    if (wr_en && bus.waddr == bus.raddr_b)       rdata_b_d = bus.wdata;
    if (clr_active && clr_addr == bus.raddr_b)   rdata_b_d = '0;
    if (ZERO_REG && bus.raddr_b == ADDR_W'(0))   rdata_b_d = '0;
  end

  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.busy     = busy;
  assign bus.clr_done = clr_done;

endmodule

// File: tb/tb_regfile32_nbit.sv
// Self-checking bench for regfile32_nbit: cycle model of the bank plus pinned literal expectations.
module tb_regfile32_nbit;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic clk;
  logic rst_n;

  regfile32_nbit_if #(.N(8)) bus ();

  regfile32_nbit #(.N(8)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Model of the bank as the outside world sees it.
  logic [7:0] m_mem [32];
  logic       m_clr;
  int         m_idx;
  logic [7:0] m_ra, m_rb;
  logic       m_busy, m_done;

  function automatic logic [7:0] mread(input logic [4:0] a, input int clr_at,
                                       input logic wr, input logic [4:0] wa, input logic [7:0] wd);
    if (ZERO_REG && a == 5'd0) return 8'h00;
    if (clr_at == int'(a))     return 8'h00;
    if (wr && wa == a)         return wd;
    return m_mem[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_mem[i] <= 8'h00;
      m_clr <= 1'b0; m_idx <= 0; m_ra <= 8'h00; m_rb <= 8'h00;
      m_busy <= 1'b0; m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_clr) begin
        m_ra <= mread(bus.raddr_a, m_idx, 1'b0, 5'd0, 8'h00);
        m_rb <= mread(bus.raddr_b, m_idx, 1'b0, 5'd0, 8'h00);
        m_mem[m_idx] <= 8'h00;
        if (m_idx == 31) begin
          m_clr <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1; m_idx <= 0;
        end else begin
          m_idx <= m_idx + 1;
        end
      end else if (bus.clr_req) begin
        m_ra <= mread(bus.raddr_a, -1, 1'b0, 5'd0, 8'h00);
        m_rb <= mread(bus.raddr_b, -1, 1'b0, 5'd0, 8'h00);
        m_clr <= 1'b1; m_idx <= 0; m_busy <= 1'b1;
      end else begin
        logic wr;
        wr = bus.we && !(ZERO_REG && bus.waddr == 5'd0);
        m_ra <= mread(bus.raddr_a, -1, wr, bus.waddr, bus.wdata);
        m_rb <= mread(bus.raddr_b, -1, wr, bus.waddr, bus.wdata);
        if (wr) m_mem[bus.waddr] <= bus.wdata;
      end
    end
  end

  // Literal expectations handed to the compare process.
  int         lit_id   = 0;
  int         lit_seen = 0;
  logic [7:0] lit_a, lit_b;
  logic       lit_busy;
  logic       started  = 1'b0;
  int         busy_run = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("rdata_a", int'(bus.rdata_a), int'(m_ra));
      chk("rdata_b", int'(bus.rdata_b), int'(m_rb));
      chk("busy", int'(bus.busy), int'(m_busy));
      chk("clr_done", int'(bus.clr_done), int'(m_done));
      if (lit_id != lit_seen) begin
        chk("lit_rdata_a", int'(bus.rdata_a), int'(lit_a));
        chk("lit_rdata_b", int'(bus.rdata_b), int'(lit_b));
        chk("lit_busy", int'(bus.busy), int'(lit_busy));
        lit_seen = lit_id;
      end
      if (!rst_n) busy_run = 0;
      else if (bus.busy) busy_run++;
      else if (busy_run != 0) begin
        chk("busy_len", busy_run, 32);
        busy_run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input logic [7:0] a, input logic [7:0] b, input logic bsy);
    lit_a = a; lit_b = b; lit_busy = bsy;
    lit_id++;
  endtask

  localparam logic [7:0] EXP0 = ZERO_REG ? 8'h00 : 8'h55;

  initial begin
    rst_n = 1'b0;
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.raddr_a = '0; bus.raddr_b = '0; bus.clr_req = 1'b0;
    tick(); tick();
    started = 1'b1;
    pin(8'h00, 8'h00, 1'b0);
    tick();
    rst_n = 1'b1;

    // Reset then read
    bus.raddr_a = 5'd3; bus.raddr_b = 5'd31;
    tick(); pin(8'h00, 8'h00, 1'b0);

    // Write then read
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 8'hA5;
    tick();
    bus.we = 1'b0; bus.raddr_a = 5'd5;
    tick(); pin(8'hA5, 8'h00, 1'b0);

    // Write-through bypass on both ports
    bus.raddr_a = 5'd7; bus.raddr_b = 5'd7;
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 8'h3C;
    tick(); pin(8'h3C, 8'h3C, 1'b0);

    // Fill every entry with 0xFF
    for (int i = 0; i < 32; i++) begin
      bus.waddr = 5'(i); bus.wdata = 8'hFF; bus.raddr_a = 5'(i); bus.raddr_b = 5'(31 - i);
      tick();
    end
    bus.we = 1'b0; bus.raddr_a = 5'd5; bus.raddr_b = 5'd7;
    tick(); pin(8'hFF, 8'hFF, 1'b0);

    // Clear with blocked writes to addr 2 and reads chasing the clear pointer
    bus.clr_req = 1'b1;
    tick(); pin(8'hFF, 8'hFF, 1'b1);
    bus.clr_req = 1'b0;
    for (int j = 0; j < 32; j++) begin
      bus.raddr_a = 5'(j + 1); bus.raddr_b = 5'(j);
      bus.we = 1'b1; bus.waddr = 5'd2; bus.wdata = 8'h11;
      tick();
      if (j == 10) pin(8'hFF, 8'h00, 1'b1);
    end
    bus.we = 1'b0;
    pin(8'h00, 8'h00, 1'b0);
    for (int i = 0; i < 32; i++) begin
      bus.raddr_a = 5'(i); bus.raddr_b = 5'(31 - i);
      tick();
    end
    bus.raddr_a = 5'd2; bus.raddr_b = 5'd5;
    tick(); pin(8'h00, 8'h00, 1'b0);

    // clr_req held high: back-to-back sequences
    for (int i = 0; i < 32; i++) begin
      bus.we = 1'b1; bus.waddr = 5'(i); bus.wdata = 8'(i * 3 + 1);
      tick();
    end
    bus.we = 1'b0;
    bus.clr_req = 1'b1;
    for (int k = 0; k < 70; k++) begin
      bus.raddr_a = 5'(k); bus.raddr_b = 5'(31 - k);
      tick();
    end
    bus.clr_req = 1'b0;
    tick(); tick();

    // Reset in the middle of a clear
    for (int i = 0; i < 4; i++) begin
      bus.we = 1'b1; bus.waddr = 5'(i + 3); bus.wdata = 8'hAA;
      tick();
    end
    bus.we = 1'b0;
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    pin(8'h00, 8'h00, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus.raddr_a = 5'(i); bus.raddr_b = 5'(31 - i);
      tick();
    end
    bus.raddr_a = 5'd4; bus.raddr_b = 5'd6;
    tick(); pin(8'h00, 8'h00, 1'b0);

    // Entry 0: write with same-cycle bypass, then plain read
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 8'h55;
    bus.raddr_a = 5'd0; bus.raddr_b = 5'd0;
    tick(); pin(EXP0, EXP0, 1'b0);
    bus.we = 1'b0;
    tick(); pin(EXP0, EXP0, 1'b0);

    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/regfile32_nbit.md
Name: regfile32_nbit

Overview:
- 32-entry, N-bit general register bank for the 8-bit CPU.
- Feeds the operand-select stage: two registered read ports drive the ALU operand paths; one write port is driven by write-back.
- Includes a hardware clear sequencer that zeroes all 32 entries, one entry per cycle, on request; a busy flag tells the control unit to stall.

Parameters:
- N, 8, data width of each register and of all data ports.
- ADDR_W, 5, address width; fixed at 5, giving 32 entries.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- we  input  1  write enable for the write port.
- waddr  input  ADDR_W  write address.
- wdata  input  N  write data.
- raddr_a  input  ADDR_W  read port A address.
- raddr_b  input  ADDR_W  read port B address.
- rdata_a  output  N  registered read data, port A.
- rdata_b  output  N  registered read data, port B.
- clr_req  input  1  request a full-bank clear (level-sampled).
- busy  output  1  high while the clear sequence runs.
- clr_done  output  1  one-cycle pulse when the clear completes.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: all 32 entries, rdata_a, rdata_b, busy, clr_done and the clear counter are 0; FSM is IDLE. Reset is effective immediately on assertion, independent of clk.
- Read latency: 1 cycle. rdata_x at edge k+1 reflects raddr_x sampled at edge k.
- Write-through bypass:
  - If we=1 and waddr==raddr_x in the same cycle (IDLE), rdata_x captures wdata, not the old entry.
  - Ports A and B bypass independently; both may hit the same address.
- Write: in IDLE, mem[waddr] <= wdata at the edge where we=1.
- FSM states: IDLE, CLEAR.
- IDLE -> CLEAR:
  - On an edge with clr_req=1: cnt <= 0 and busy <= 1.
  - A write presented in the same cycle is dropped; clear has priority.
- CLEAR, each cycle:
  - mem[cnt] <= 0; cnt <= cnt+1.
  - we is ignored and the write is dropped; the caller must stall on busy.
  - clr_req is ignored.
- CLEAR -> IDLE:
  - At the edge where cnt==31 is cleared: busy <= 0, clr_done <= 1 for exactly one cycle, cnt wraps to 0.
  - Total busy duration: 32 cycles.
- Reads during CLEAR:
  - Return the stored value.
  - If raddr_x==cnt in that cycle, return 0 (clear bypass).
- Reset mid-CLEAR: everything returns to reset values; clr_done is not pulsed.
- clr_req held high continuously: a new clear starts on the first IDLE cycle after clr_done, i.e. back-to-back 32-cycle sequences separated by 1 IDLE cycle.
- Widths: addresses are unsigned; no arithmetic on data; cnt is ADDR_W bits and wraps naturally.

Optional Feature:
- Macro: REGFILE_ZERO_REG_EN.
- Defined: entry 0 is hardwired to zero.
  - Writes to address 0 are discarded.
  - Reads of address 0 return 0, including bypass (we=1, waddr=0, raddr=0 gives 0).
  - Clear sequence behaviour is unchanged.
- Undefined: entry 0 is an ordinary register.

Decomposition:
- Shared package cpu8_pkg holds:
  - REG_ADDR_W=5 and REG_COUNT=32.
  - The FSM state encoding typedef (IDLE=1'b0, CLEAR=1'b1).
- Natural sub-module: regfile_clr_seq, containing the FSM, counter, busy and clr_done. It outputs clr_active and clr_addr to the storage array.

Test Plan:
- Reset then read: reset; raddr_a=3, raddr_b=31 -> rdata_a=0x00 and rdata_b=0x00 after 1 cycle.
- Write/read: we=1, waddr=5, wdata=0xA5; next cycle raddr_a=5 -> rdata_a=0xA5 one cycle later.
- Bypass: raddr_a=7, raddr_b=7, we=1, waddr=7, wdata=0x3C in the same cycle -> rdata_a=0x3C and rdata_b=0x3C next cycle.
- Clear: fill all entries with 0xFF; pulse clr_req; write 0x11 to addr 2 during busy. Expect:
  - busy high exactly 32 cycles.
  - clr_done a single 1-cycle pulse.
  - Every entry reads 0x00 afterwards; addr 2 was not written.
- Reset mid-clear: assert rst_n=0 at clear cycle 10 -> busy=0 immediately, clr_done never pulses, all entries read 0.
- REGFILE_ZERO_REG_EN: write 0x55 to addr 0, including a same-cycle bypass read -> rdata=0x00 with the macro defined; rdata=0x55 without it.
